// File: rtl/accu_serializer.sv
// Packet serializer feeding the accumulator: takes one packed packet per handshake and
// streams it one word per beat with optional idle gaps, plus a last marker and expected sum.
module accu_serializer #(
    parameter int DATA_W = 8,
    parameter int WORDS  = 4,
    parameter int GAP_W  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_W*WORDS-1:0]           in_data,
    input  logic [GAP_W-1:0]                  gap,
    output logic                              valid_out,
    output logic [DATA_W-1:0]                 data_out,
    output logic                              last_out,
    output logic [DATA_W+$clog2(WORDS)-1:0]   exp_sum,
    output logic                              busy
);

    localparam int SUM_W = DATA_W + $clog2(WORDS);
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [GAP_W-1:0]          cnt_q, cnt_d;
    logic [GAP_W-1:0]          gap_q, gap_d;
    logic [DATA_W*WORDS-1:0]   pkt_q, pkt_d;
    logic [DATA_W-1:0]         data_q, data_d;
    logic [SUM_W-1:0]          sum_q, sum_d;
    logic                      valid_q, valid_d;
    logic                      last_q, last_d;
    logic                      busy_q, busy_d;

    logic                      accept;
    logic [SUM_W-1:0]          pkt_sum;
    logic [IDX_W-1:0]          idx_next;

    // Ready only when idle or on the final beat, so a new packet can follow with no bubble.
    assign in_ready = !rst && ((state_q == IDLE) || ((state_q == SEND) && (idx_q == LAST_IDX)));
    assign accept   = in_valid && in_ready;
    assign idx_next = idx_q + IDX_W'(1);

    always_comb begin
        pkt_sum = '0;
        for (int i = 0; i < WORDS; i++) begin
            pkt_sum = pkt_sum + SUM_W'(in_data[i*DATA_W +: DATA_W]);
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        pkt_d   = pkt_q;
        data_d  = data_q;
        sum_d   = sum_q;
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = busy_q;

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (accept) begin
                    state_d = SEND;
                    idx_d   = '0;
                    pkt_d   = in_data;
                    gap_d   = gap;
                    sum_d   = pkt_sum;
                    data_d  = in_data[DATA_W-1:0];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            SEND: begin
                if (idx_q == LAST_IDX) begin
                    if (accept) begin
                        state_d = SEND;
                        idx_d   = '0;
                        pkt_d   = in_data;
                        gap_d   = gap;
                        sum_d   = pkt_sum;
                        data_d  = in_data[DATA_W-1:0];
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else if (gap_q == '0) begin
                    idx_d   = idx_next;
                    data_d  = pkt_q[idx_next*DATA_W +: DATA_W];
                    valid_d = 1'b1;
                    last_d  = (idx_next == LAST_IDX);
                end else begin
                    state_d = GAP;
                    cnt_d   = gap_q;
                end
            end
            GAP: begin
                if (cnt_q == GAP_W'(1)) begin
                    state_d = SEND;
                    idx_d   = idx_next;
                    data_d  = pkt_q[idx_next*DATA_W +: DATA_W];
                    valid_d = 1'b1;
                    last_d  = (idx_next == LAST_IDX);
                end else begin
                    cnt_d = cnt_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Reset drops any packet in flight; no partial last beat is ever emitted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            pkt_q   <= '0;
            data_q  <= '0;
            sum_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            pkt_q   <= pkt_d;
            data_q  <= data_d;
            sum_q   <= sum_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign last_out  = last_q;
    assign exp_sum   = sum_q;
    assign busy      = busy_q;

endmodule

// File: doc/accu_serializer.md
Name: accu_serializer

Overview:
- Packet source for the accumulator datapath. Accepts one packed packet of WORDS data words over a valid/ready handshake and emits them one word per beat on a serial valid/data stream, matching the accumulator's serial data/valid input.
- Emits a last-beat marker and the expected accumulated sum, so a bench or an upstream checker can compare it against the accumulator's result.

Parameters:
- DATA_W, 8, width of one serial word
- WORDS, 4, words per packet (>=2)
- GAP_W, 4, width of the inter-word idle-gap field
- SUM_W, DATA_W+$clog2(WORDS) (10 at defaults), width of expected sum; derived, not overridden

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  packet offered
- in_ready  output  1  packet can be accepted this cycle
- in_data  input  DATA_W*WORDS  packet; word 0 = in_data[DATA_W-1:0]
- gap  input  GAP_W  idle cycles inserted between words of the packet
- valid_out  output  1  data_out carries a word this cycle
- data_out  output  DATA_W  current word
- last_out  output  1  current word is the packet's final word
- exp_sum  output  SUM_W  sum of all packet words; valid when last_out=1
- busy  output  1  a packet is in flight

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst: sampled only on the rising edge of clk.
- Reset values:
  - valid_out=0, last_out=0, busy=0, data_out=0, exp_sum=0.
  - FSM=IDLE, word index=0, gap counter=0.
  - in_ready=1 is the first cycle after reset is released; in_ready=0 while rst=1.
- Acceptance: a packet is accepted on a rising edge where in_valid && in_ready. On that edge the block registers in_data, gap and exp_sum.
  - exp_sum is the full-width sum of the WORDS words, with no truncation.
- FSM states: IDLE, SEND, GAP. All outputs are registered.
  - IDLE: valid_out=0. On accept -> SEND with index 0, so word 0 appears in the cycle after the accept edge (latency 1).
  - SEND: valid_out=1, data_out=word[index], last_out=(index==WORDS-1).
    - Not last, gap==0 -> stay in SEND, index+1.
    - Not last, gap>0 -> GAP, counter=gap.
    - Last, accept on the same edge -> SEND with index 0 of the new packet, with no bubble.
    - Last, no accept -> IDLE.
  - GAP: valid_out=0, last_out=0. Counter decrements each cycle. At counter==1 -> SEND, index+1.
- Timing: word i appears exactly at cycle accept+1+i*(gap+1). No gap is inserted between packets.
- in_ready = (state==IDLE) || (state==SEND && index==WORDS-1). It is combinational from state only, never from in_valid.
- busy=1 in SEND/GAP; it drops in the cycle after the last word unless a new packet was accepted.
- data_out and exp_sum hold their last values when valid_out=0. Consumers must qualify them with valid_out/last_out.
- When in_ready=0, in_valid, in_data and gap are ignored. A new packet cannot alter the packet in flight.
- Reset mid-packet: remaining words are dropped and valid_out=0 on the next cycle. No partial last_out is produced.
- gap is captured per packet. Changing gap mid-packet has no effect until the next accept.

Test Plan:
- Basic packet: rst pulse, then in_data=32'h04030201, gap=0, in_valid for 1 cycle -> data_out 01,02,03,04 on 4 consecutive cycles starting 1 cycle after accept; last_out only on 04; exp_sum=10'd10.
- Max-value sum: in_data=32'hFFFFFFFF, gap=0 -> four words of FF; exp_sum=10'h3FC (1020) with last_out, checking no overflow truncation.
- Gap timing: in_data=32'h40302010, gap=2, accept at cycle T -> valid_out at T+1, T+4, T+7, T+10 only; data 10,20,30,40; in_ready=1 only at T+10.
- Back-to-back: in_valid held high with packet A=32'h04030201 then B=32'h08070605, gap=0 -> 8 consecutive valid words 01..08; last_out on 04 and 08; exp_sum 10 then 26; no idle cycle between packets.
- Backpressure: keep in_valid=1 and change in_data while busy and not on the last beat -> in_ready=0 and the stream is unaffected; the new value is accepted only on the last-beat cycle.
- Reset mid-packet: assert rst after word 1 of 32'h04030201 -> next cycle valid_out=0, busy=0, last_out never asserted; a following packet streams correctly from word 0.
